// File: rtl/uart_pixel_packer_pkg.sv
// uart_pixel_packer_pkg: shared types, header constants and width helper
//   state_e  - packer FSM states
//   HDR_B0/1 - frame header sync bytes (header option only)
//   cnt_w()  - bits needed to hold 0..n inclusive
package uart_pixel_packer_pkg;

    typedef enum logic [1:0] {IDLE, HDR, RECV, DONE} state_e;

    localparam logic [7:0] HDR_B0 = 8'hA5;
    localparam logic [7:0] HDR_B1 = 8'h5A;

    function automatic int cnt_w(input longint n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/pack_timeout_cnt.sv
// pack_timeout_cnt: idle-cycle counter that flags expiry after TIMEOUT_CYC enabled cycles
//   clk, rst_n - clock, asynchronous active-low reset
//   clr        - zero the counter (takes priority, suppresses expiry)
//   en         - count this cycle
//   expired    - single-cycle flag in the cycle the count reaches TIMEOUT_CYC
module pack_timeout_cnt
    import uart_pixel_packer_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int TW = cnt_w(TIMEOUT_CYC);
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYC - 1);

    logic [TW-1:0] cnt_q, cnt_d;

    always_comb begin
        expired = en && !clr && (cnt_q == LAST);
        cnt_d   = (clr || expired) ? '0 : en ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_pixel_packer.sv
// uart_pixel_packer: packs UART bytes into RGB565 pixels and frames them for the DDR write FIFO
//   clk, rst_n        - wr_clk domain clock, asynchronous active-low reset
//   rx_din, rx_vld    - received byte and its single-cycle strobe
//   wr_req            - frame-start pulse
//   wr_address_beign  - frame start address (constant)
//   wr_address_end    - frame end address, exclusive (constant)
//   wr_din, wr_din_vld- pixel {hi, lo} and its strobe
//   frame_done        - pulse after the last pixel of a frame
//   frame_err         - pulse on idle-timeout abort
// Optional macro UART_PIXEL_PACKER_HEADER_EN: frames start only after 0xA5 0x5A.
module uart_pixel_packer
    import uart_pixel_packer_pkg::*;
#(
    parameter int     H_PIX       = 1280,
    parameter int     V_PIX       = 720,
    parameter int     ADDR_WIDTH  = 29,
    parameter longint BASE_ADDR   = 0,
    parameter int     TIMEOUT_CYC = 1_000_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            rx_din,
    input  logic                  rx_vld,
    output logic                  wr_req,
    output logic [ADDR_WIDTH-1:0] wr_address_beign,
    output logic [ADDR_WIDTH-1:0] wr_address_end,
    output logic [15:0]           wr_din,
    output logic                  wr_din_vld,
    output logic                  frame_done,
    output logic                  frame_err
);

    localparam longint TOTAL = longint'(H_PIX) * longint'(V_PIX);
    localparam int PW = cnt_w(TOTAL);
    localparam logic [PW-1:0] TOTAL_P = PW'(TOTAL);

    generate
        if (BASE_ADDR + TOTAL >= (longint'(1) << ADDR_WIDTH)) begin : g_addr_chk
            $error("uart_pixel_packer: frame address window wraps ADDR_WIDTH");
        end
    endgenerate

    assign wr_address_beign = ADDR_WIDTH'(BASE_ADDR);
    assign wr_address_end   = ADDR_WIDTH'(BASE_ADDR + TOTAL);

    state_e        state_q, state_d;
    logic [7:0]    hi_q, hi_d;
    logic          phase_q, phase_d;
    logic [PW-1:0] cnt_q, cnt_d;
    logic          wr_req_q, wr_req_d;
    logic [15:0]   wr_din_q, wr_din_d;
    logic          wr_din_vld_q, wr_din_vld_d;
    logic          frame_done_q, frame_done_d;
    logic          frame_err_q, frame_err_d;
    logic          active, expired;

    assign active = (state_q == RECV) || (state_q == HDR);

    // A byte in the expiry cycle clears the counter, so the byte always wins.
    pack_timeout_cnt #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_tmo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (rx_vld || !active),
        .en      (active),
        .expired (expired)
    );

    always_comb begin
        state_d      = state_q;
        hi_d         = hi_q;
        phase_d      = phase_q;
        cnt_d        = cnt_q;
        wr_req_d     = 1'b0;
        wr_din_d     = wr_din_q;
        wr_din_vld_d = 1'b0;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (rx_vld) begin
`ifdef UART_PIXEL_PACKER_HEADER_EN
                    if (rx_din == HDR_B0) state_d = HDR;
`else
                    hi_d     = rx_din;
                    phase_d  = 1'b1;
                    wr_req_d = 1'b1;
                    state_d  = RECV;
`endif
                end
            end
`ifdef UART_PIXEL_PACKER_HEADER_EN
            HDR: begin
                if (rx_vld) begin
                    if (rx_din == HDR_B1) begin
                        wr_req_d = 1'b1;
                        phase_d  = 1'b0;
                        state_d  = RECV;
                    end else if (rx_din != HDR_B0) begin
                        state_d = IDLE;
                    end
                end else if (expired) begin
                    frame_err_d = 1'b1;
                    state_d     = IDLE;
                end
            end
`endif
            RECV: begin
                if (rx_vld) begin
                    if (!phase_q) begin
                        hi_d    = rx_din;
                        phase_d = 1'b1;
                    end else begin
                        wr_din_d     = {hi_q, rx_din};
                        wr_din_vld_d = 1'b1;
                        cnt_d        = cnt_q + 1'b1;
                        phase_d      = 1'b0;
                        if (cnt_d == TOTAL_P) state_d = DONE;
                    end
                end else if (expired) begin
                    frame_err_d = 1'b1;
                    cnt_d       = '0;
                    phase_d     = 1'b0;
                    state_d     = IDLE;
                end
            end
            DONE: begin
                frame_done_d = 1'b1;
                cnt_d        = '0;
                phase_d      = 1'b0;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            hi_q         <= '0;
            phase_q      <= 1'b0;
            cnt_q        <= '0;
            wr_req_q     <= 1'b0;
            wr_din_q     <= '0;
            wr_din_vld_q <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            hi_q         <= hi_d;
            phase_q      <= phase_d;
            cnt_q        <= cnt_d;
            wr_req_q     <= wr_req_d;
            wr_din_q     <= wr_din_d;
            wr_din_vld_q <= wr_din_vld_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign wr_req     = wr_req_q;
    assign wr_din     = wr_din_q;
    assign wr_din_vld = wr_din_vld_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;

endmodule
